// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator sharing one period counter.
// Each channel has a shadow/active duty pair so updates land only on period
// boundaries. Supports edge-aligned and center-aligned counting, plus a
// one-cycle period-start strobe aligned with the first output cycle.
module pwm_multichannel #(
    parameter int BIT_WIDTH = 10,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        center_mode,
    input  logic [BIT_WIDTH-1:0]        max_value,
    input  logic [NUM_CH*BIT_WIDTH-1:0] duty,
    input  logic                        duty_load,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        period_start,
    output logic                        duty_pending
);

    logic [BIT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 dir_up_reg, dir_up_next;
    logic [BIT_WIDTH-1:0] m_act_reg;
    logic                 mode_act_reg;
    logic                 pending_reg, pending_next;

    logic                 boundary;
    logic                 latch_cfg;
    logic                 load_direct;
    logic                 load_shadow;
    logic                 apply_shadow;
    logic [NUM_CH-1:0]    pwm_next;
    logic                 period_start_next;

    // Boundary detection, duty-path control and counter sequencing.
    always_comb begin
        boundary          = 1'b0;
        cnt_next          = cnt_reg;
        dir_up_next       = dir_up_reg;
        pending_next      = pending_reg;
        latch_cfg         = 1'b0;
        load_direct       = 1'b0;
        load_shadow       = 1'b0;
        apply_shadow      = 1'b0;
        period_start_next = 1'b0;

        // Last cycle of a period: top of the ramp in edge mode, second
        // cycle at zero (falling leg) in center mode.
        if (mode_act_reg) begin
            boundary = !dir_up_reg && (cnt_reg == '0);
        end else begin
            boundary = (cnt_reg == m_act_reg);
        end

        if (!enable) begin
            cnt_next     = '0;
            dir_up_next  = 1'b1;
            pending_next = 1'b0;
            latch_cfg    = 1'b1;
            load_direct  = duty_load;
        end else begin
            // The cycle counting up from zero is the first of a period.
            period_start_next = dir_up_reg && (cnt_reg == '0);
            if (boundary) begin
                cnt_next     = '0;
                dir_up_next  = 1'b1;
                pending_next = 1'b0;
                latch_cfg    = 1'b1;
                load_direct  = duty_load;
                apply_shadow = pending_reg && !duty_load;
            end else begin
                if (dir_up_reg) begin
                    if (mode_act_reg && (cnt_reg == m_act_reg)) begin
                        // Hold the top value for a second cycle on the turn.
                        dir_up_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + BIT_WIDTH'(1);
                    end
                end else begin
                    cnt_next = cnt_reg - BIT_WIDTH'(1);
                end
                if (duty_load) begin
                    load_shadow  = 1'b1;
                    pending_next = 1'b1;
                end
            end
        end
    end

    // Shared counter, latched period configuration and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            dir_up_reg   <= 1'b1;
            m_act_reg    <= '0;
            mode_act_reg <= 1'b0;
            pending_reg  <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            dir_up_reg  <= dir_up_next;
            pending_reg <= pending_next;
            if (latch_cfg) begin
                m_act_reg    <= max_value;
                mode_act_reg <= center_mode;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [BIT_WIDTH-1:0] duty_sh_reg;
            logic [BIT_WIDTH-1:0] duty_act_reg;

            // Per-channel shadow capture and boundary/idle transfer to active.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_sh_reg  <= '0;
                    duty_act_reg <= '0;
                end else begin
                    if (load_shadow) begin
                        duty_sh_reg <= duty[gi*BIT_WIDTH +: BIT_WIDTH];
                    end
                    if (load_direct) begin
                        duty_act_reg <= duty[gi*BIT_WIDTH +: BIT_WIDTH];
                    end else if (apply_shadow) begin
                        duty_act_reg <= duty_sh_reg;
                    end
                end
            end

            assign pwm_next[gi] = enable && (cnt_reg < duty_act_reg);
        end
    endgenerate

    // Registered outputs; pending is stretched one cycle so it drops
    // together with the period-start strobe of the period that applies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
            duty_pending <= 1'b0;
        end else begin
            pwm_out      <= pwm_next;
            period_start <= period_start_next;
            duty_pending <= pending_next | pending_reg;
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: a period-position reference model feeds a
// scoreboard queue each clock; a negedge monitor pops and compares outputs.
// Directed tasks measure period lengths and per-channel high times.
module tb_pwm_multichannel;

    localparam int BW = 10;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             center_mode;
    logic [BW-1:0]    max_value;
    logic [NC*BW-1:0] duty;
    logic             duty_load;
    logic [NC-1:0]    pwm_out;
    logic             period_start;
    logic             duty_pending;

    int errors = 0;
    int checks = 0;

    pwm_multichannel #(.BIT_WIDTH(BW), .NUM_CH(NC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .center_mode  (center_mode),
        .max_value    (max_value),
        .duty         (duty),
        .duty_load    (duty_load),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_pending (duty_pending)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // State is the position inside the current period; the counter value
    // is derived arithmetically from it.
    typedef logic [NC+1:0] exp_t;
    exp_t exp_q[$];

    int m_m, pos_m;
    bit mode_m, pend_m;
    int dact[NC];
    int dsh[NC];

    always @(posedge clk or negedge rst_n) begin : model
        logic [NC-1:0] ep;
        logic          eps;
        bit            np;
        int            plen, c;
        if (!rst_n) begin
            m_m = 0; pos_m = 0; mode_m = 0; pend_m = 0;
            for (int k = 0; k < NC; k++) begin dact[k] = 0; dsh[k] = 0; end
            exp_q.delete();
        end else begin
            ep = '0; eps = 1'b0; np = 1'b0;
            if (!enable) begin
                pos_m = 0; m_m = int'(max_value); mode_m = center_mode;
                if (duty_load)
                    for (int k = 0; k < NC; k++) dact[k] = int'(duty[k*BW +: BW]);
            end else begin
                plen = mode_m ? 2 * (m_m + 1) : m_m + 1;
                c = (mode_m && pos_m > m_m) ? (2 * m_m + 1 - pos_m) : pos_m;
                for (int k = 0; k < NC; k++) ep[k] = (c < dact[k]);
                eps = (pos_m == 0);
                if (pos_m == plen - 1) begin
                    pos_m = 0; m_m = int'(max_value); mode_m = center_mode;
                    if (duty_load)
                        for (int k = 0; k < NC; k++) dact[k] = int'(duty[k*BW +: BW]);
                    else if (pend_m)
                        for (int k = 0; k < NC; k++) dact[k] = dsh[k];
                end else begin
                    pos_m++;
                    np = pend_m;
                    if (duty_load) begin
                        for (int k = 0; k < NC; k++) dsh[k] = int'(duty[k*BW +: BW]);
                        np = 1'b1;
                    end
                end
            end
            exp_q.push_back({ep, eps, np | pend_m});
            pend_m = np;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({pwm_out, period_start, duty_pending} !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got pwm=%b ps=%b pend=%b required pwm=%b ps=%b pend=%b",
                         $time, pwm_out, period_start, duty_pending,
                         e[NC+1:2], e[1], e[0]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic wait_ps();
        int n = 0;
        while (!period_start && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!period_start) chk("wait_period_start_timeout", 0, 1);
    endtask

    function automatic logic [NC*BW-1:0] pack(input int d0, d1, d2, d3);
        pack = {BW'(d3), BW'(d2), BW'(d1), BW'(d0)};
    endfunction

    // Called at a negedge showing period_start; counts until the next one.
    // kind bit0: duty load, bit1: max/mode change, bit2: check pending after load.
    task automatic measure(input string tag, input int exp_per,
                           input int e0, e1, e2, e3,
                           input int ev_at, input int kind,
                           input logic [NC*BW-1:0] ev_duty,
                           input int ev_max, input bit ev_mode);
        int cyc = 0;
        int hi[NC];
        for (int k = 0; k < NC; k++) hi[k] = 0;
        do begin
            for (int k = 0; k < NC; k++) hi[k] += int'(pwm_out[k]);
            if (cyc == ev_at) begin
                if (kind[0]) begin duty = ev_duty; duty_load = 1'b1; end
                if (kind[1]) begin max_value = BW'(ev_max); center_mode = ev_mode; end
            end
            if (cyc == ev_at + 1) begin
                duty_load = 1'b0;
                if (kind[2]) chk({tag, "_pending_after_load"}, int'(duty_pending), 1);
            end
            cyc++;
            @(negedge clk);
        end while (!period_start && cyc < 5000);
        duty_load = 1'b0;
        chk({tag, "_period"}, cyc, exp_per);
        chk({tag, "_high_ch0"}, hi[0], e0);
        chk({tag, "_high_ch1"}, hi[1], e1);
        chk({tag, "_high_ch2"}, hi[2], e2);
        chk({tag, "_high_ch3"}, hi[3], e3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; enable = 1'b0; center_mode = 1'b0;
        max_value = '0; duty = '0; duty_load = 1'b0;
        #23;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_ps", int'(period_start), 0);
        chk("reset_pending", int'(duty_pending), 0);
        @(negedge clk) rst_n = 1'b1;

        // Edge mode M=1022, loads while idle.
        @(negedge clk);
        max_value = 10'd1022;
        duty = pack(1, 511, 1023, 0);
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        enable = 1'b1;
        wait_ps();
        measure("edge", 1023, 1, 511, 1023, 0, -5, 0, '0, 0, 0);

        // Mid-period update at cnt=100.
        measure("midload", 1023, 1, 511, 1023, 0, 99, 5, pack(1, 256, 1023, 0), 0, 0);
        measure("after_midload", 1023, 1, 256, 1023, 0, -5, 0, '0, 0, 0);

        // Load on the boundary cycle (two cycles before the next strobe).
        repeat (1021) @(negedge clk);
        duty = pack(5, 256, 1023, 0);
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        chk("bnd_pending_low0", int'(duty_pending), 0);
        @(negedge clk);
        chk("bnd_pending_low1", int'(duty_pending), 0);
        chk("bnd_period_start", int'(period_start), 1);
        measure("bnd_applied", 1023, 5, 256, 1023, 0, -5, 0, '0, 0, 0);

        // Change max/mode mid-period: current period unaffected.
        measure("cfgchg", 1023, 5, 256, 1023, 0, 50, 2, '0, 99, 1);
        measure("center99", 200, 10, 200, 200, 0, -5, 0, '0, 0, 0);

        // Center mode M=9, ch0 duty 3 then 10.
        measure("to_center9", 200, 10, 200, 200, 0, 10, 3, pack(3, 256, 1023, 0), 9, 1);
        measure("center9", 20, 6, 20, 20, 0, 2, 1, pack(10, 256, 1023, 0), 0, 0);
        measure("center9_full", 20, 20, 20, 20, 0, -5, 0, '0, 0, 0);

        // M=0 edge mode: one-cycle periods.
        measure("to_m0", 20, 20, 20, 20, 0, 4, 2, '0, 0, 0);
        measure("m0_edge", 1, 1, 1, 1, 0, -5, 0, '0, 0, 0);

        // Randomized traffic, checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            duty_load = ($urandom_range(0, 14) == 0);
            if (duty_load)
                duty = pack($urandom_range(0, 20), $urandom_range(0, 20),
                            $urandom_range(0, 20), $urandom_range(0, 1023));
            if ($urandom_range(0, 60) == 0) enable = ~enable;
            if ($urandom_range(0, 150) == 0) begin
                max_value   = BW'($urandom_range(0, 15));
                center_mode = 1'($urandom_range(0, 1));
            end
        end

        // Reset asserted mid-pulse, away from the clock edge.
        @(negedge clk);
        duty_load = 1'b0; enable = 1'b0; max_value = 10'd1022; center_mode = 1'b0;
        @(negedge clk);
        duty = pack(600, 600, 600, 600);
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        enable = 1'b1;
        repeat (50) @(negedge clk);
        chk("pre_reset_pwm_high", int'(pwm_out), 15);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_pwm", int'(pwm_out), 0);
        chk("async_reset_ps", int'(period_start), 0);
        chk("async_reset_pending", int'(duty_pending), 0);
        @(negedge clk) rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (40) begin
                @(negedge clk);
                seen |= int'(pwm_out);
            end
            chk("post_reset_pwm_low", seen, 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Multi-channel, parametrised successor to the single-channel PWM generator. It drives `NUM_CH` PWM outputs from one shared period counter. Each channel has a double-buffered duty register, so updates take effect only at period boundaries and never produce glitched pulses. Edge-aligned and center-aligned modes are supported, and a period-start strobe is provided for downstream sampling logic such as ADC triggers and duty measurement.

## Interface
- `BIT_WIDTH`, 10, width of counter, `max_value` and each duty field
- `NUM_CH`, 4, number of PWM channels (1..32)
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run counter; low = idle
- `center_mode`  in  1  0 = edge-aligned, 1 = center-aligned (latched at period boundary)
- `max_value`  in  BIT_WIDTH  period terminal count M (latched at period boundary)
- `duty`  in  NUM_CH*BIT_WIDTH  duty values; channel k at bits [k*BIT_WIDTH +: BIT_WIDTH]
- `duty_load`  in  1  single-cycle strobe; captures all `duty` fields into shadow registers
- `pwm_out`  out  NUM_CH  registered PWM outputs
- `period_start`  out  1  one-cycle pulse aligned with the first output cycle of each period
- `duty_pending`  out  1  shadow holds values not yet applied

## Operation
- Registers:
  - counter `cnt` (BIT_WIDTH)
  - direction `dir_up`
  - latched `m_act` and `mode_act`
  - per channel: shadow `duty_sh[k]` and active `duty_act[k]`
  - pending flag
- Edge mode: `cnt` runs 0,1,…,m_act, then 0. Period = m_act+1 cycles.
- Center mode: `cnt` runs 0..m_act up, then m_act..0 down, with each endpoint held for two cycles. Every value appears twice, so period = 2*(m_act+1) cycles.
- Channel compare: `pwm_out[k]` is high when `cnt < duty_act[k]` (unsigned, full BIT_WIDTH).
  - Edge mode: high time = duty cycles.
  - Center mode: high time = 2*duty cycles, centered on the cnt=0 turnaround.
- Duty saturation:
  - duty ≥ m_act+1 → constant high.
  - duty = 0 → constant low.
  - 100% is reachable only when M ≤ 2^BIT_WIDTH−2.
- Period boundary:
  - Defined as the last cycle of a period: edge mode cnt==m_act; center mode cnt==0 with dir down, second cycle.
  - On that cycle: `m_act`←`max_value`, `mode_act`←`center_mode`, and if pending, `duty_act`←`duty_sh` and pending clears.
  - `cnt` restarts at 0 with dir up.
- `duty_load` while enabled, not on a boundary cycle: `duty_sh`←`duty`, pending set. A later load before the boundary overwrites the shadow; the last load wins.
- `duty_load` on a boundary cycle: `duty` goes directly into `duty_act` for the next period and pending stays 0.
- `enable` low:
  - `cnt`=0, dir up, all `pwm_out` low, no `period_start`.
  - `duty_load` writes `duty_act` directly, and `m_act`/`mode_act` track inputs every cycle.
  - Pending clears.
- `enable` rising: the counter starts at 0 on the next cycle, and that cycle begins a period.

## Timing
- Reset (async assert, sync release): `pwm_out`=0, `period_start`=0, `duty_pending`=0, `cnt`=0, dir up, all duty registers 0, `m_act`=0, `mode_act`=0.
- Output latency: `pwm_out` and `period_start` are registered, so they reflect `cnt` and `duty_act` of the previous cycle (1-cycle latency).
- `period_start` is high exactly once per period, in the cycle `pwm_out` reflects cnt=0 of the up phase.
- `duty_pending` rises the cycle after `duty_load` and falls the cycle after the boundary that applies it (same cycle as `period_start`).
- M=0:
  - Edge mode: period 1, output high iff duty ≥ 1; `period_start` high every cycle.
  - Center mode: period 2.
- `max_value` or `center_mode` change mid-period: no effect until the next boundary.
- Reset mid-period: outputs low immediately (asynchronous); all state is lost, including pending shadows.

## Test plan
- BIT_WIDTH=10, M=1022, edge mode. While disabled, load duties 1/511/1023/0, then enable. Required per channel:
  - ch0: period 1023 cycles, high 1.
  - ch1: high 511.
  - ch2: constant high.
  - ch3: constant low.
  - `period_start` every 1023 cycles.
- Mid-period update: ch1 duty 511→256 loaded at cnt=100. Required:
  - Current period high stays 511; next period high 256.
  - `duty_pending` high from the cycle after load until `period_start`.
- Center mode, M=9, ch0 duty 3. Required:
  - Period 20 cycles, high 6 contiguous cycles centered on cnt=0.
  - ch0 duty 10: constant high.
- `duty_load` asserted exactly on the boundary cycle. Required: new duty applies in the immediately following period, and `duty_pending` never asserts.
- Change `max_value` 1022→99 and `center_mode` 0→1 mid-period. Required: current period still 1023 cycles, following periods 200 cycles.
- Assert `rst_n` low mid-pulse, off the clock edge. Required:
  - `pwm_out`=0 and `period_start`=0 immediately.
  - After release and enable, all outputs stay low (duties reset to 0) until a new load.
